// File: rtl/river_mem_arbiter.sv
// river_mem_arbiter: shares the single River bridge request/response channel
// between the instruction cache (path 0) and the data cache (path 1).
// Only one transaction is outstanding at a time.
// Optional feature: define RIVER_MEM_ARB_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority and path 1 wins.
module river_mem_arbiter #(
  parameter int unsigned abits    = 48,
  parameter int unsigned linebits = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [1:0]                i_req_valid,
  output logic [1:0]                o_req_ready,
  input  logic [1:0]                i_req_write,
  input  logic [1:0]                i_req_cached,
  input  logic [2*abits-1:0]        i_req_addr,
  input  logic [5:0]                i_req_size,
  input  logic [2*linebits-1:0]     i_req_wdata,
  input  logic [2*linebits/8-1:0]   i_req_wstrb,
  output logic [1:0]                o_resp_valid,
  output logic [linebits-1:0]       o_resp_data,
  output logic                      o_resp_err,
  input  logic [1:0]                i_resp_ready,
  output logic                      o_mem_req_valid,
  input  logic                      i_mem_req_ready,
  output logic                      o_mem_req_path,
  output logic                      o_mem_req_write,
  output logic                      o_mem_req_cached,
  output logic [abits-1:0]          o_mem_req_addr,
  output logic [2:0]                o_mem_req_size,
  output logic [linebits-1:0]       o_mem_req_wdata,
  output logic [linebits/8-1:0]     o_mem_req_wstrb,
  input  logic                      i_mem_resp_valid,
  input  logic [linebits-1:0]       i_mem_resp_data,
  input  logic                      i_mem_resp_err,
  output logic                      o_mem_resp_ready
);

  localparam int unsigned strb_w = linebits / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic                  r_write;
  logic                  r_cached;
  logic [abits-1:0]      r_addr;
  logic [2:0]            r_size;
  logic [linebits-1:0]   r_wdata;
  logic [strb_w-1:0]     r_wstrb;
  logic [linebits-1:0]   r_rdata;
  logic                  r_err;
  logic                  w_grant;
  logic                  w_accept;
  logic                  w_in_req;
  logic                  w_in_resp;

`ifdef RIVER_MEM_ARB_RR_EN
  logic                  r_last_grant;

  // Round-robin: alternate on contention, otherwise grant the lone requester
  always_comb begin
    w_grant = i_req_valid[1];
    if (&i_req_valid) begin
      w_grant = ~r_last_grant;
    end
  end
`else
  // Fixed priority: path 1 (data cache) wins on contention
  assign w_grant = i_req_valid[1];
`endif

  assign w_accept  = (r_state == ST_IDLE) && (|i_req_valid);
  assign w_in_req  = (r_state == ST_REQ);
  assign w_in_resp = (r_state == ST_RESP);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt      = r_state;
    o_req_ready      = 2'b00;
    o_mem_req_valid  = 1'b0;
    o_mem_resp_ready = 1'b0;
    o_resp_valid     = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (|i_req_valid) begin
          o_req_ready = 2'b01 << w_grant;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        o_mem_resp_ready = 1'b1;
        if (i_mem_resp_valid) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        o_resp_valid = 2'b01 << r_owner;
        if (i_resp_ready[r_owner]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_rst) begin
      o_req_ready = 2'b00;
    end
  end

  // Request capture on accept, response capture from the bridge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner  <= 1'b0;
      r_write  <= 1'b0;
      r_cached <= 1'b0;
      r_addr   <= '0;
      r_size   <= 3'd0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
`ifdef RIVER_MEM_ARB_RR_EN
      r_last_grant <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_owner  <= w_grant;
        r_write  <= i_req_write[w_grant];
        r_cached <= i_req_cached[w_grant];
        r_addr   <= w_grant ? i_req_addr[abits +: abits] : i_req_addr[0 +: abits];
        r_size   <= w_grant ? i_req_size[5:3] : i_req_size[2:0];
        r_wdata  <= w_grant ? i_req_wdata[linebits +: linebits] : i_req_wdata[0 +: linebits];
        r_wstrb  <= w_grant ? i_req_wstrb[strb_w +: strb_w] : i_req_wstrb[0 +: strb_w];
`ifdef RIVER_MEM_ARB_RR_EN
        r_last_grant <= w_grant;
`endif
      end
      if ((r_state == ST_WAIT) && i_mem_resp_valid) begin
        r_rdata <= i_mem_resp_data;
        r_err   <= i_mem_resp_err;
      end
    end
  end

  // Payload outputs are only driven while their phase is active
  assign o_mem_req_path   = w_in_req & r_owner;
  assign o_mem_req_write  = w_in_req & r_write;
  assign o_mem_req_cached = w_in_req & r_cached;
  assign o_mem_req_addr   = w_in_req ? r_addr : '0;
  assign o_mem_req_size   = w_in_req ? r_size : 3'd0;
  assign o_mem_req_wdata  = w_in_req ? r_wdata : '0;
  assign o_mem_req_wstrb  = w_in_req ? r_wstrb : '0;
  assign o_resp_data      = w_in_resp ? r_rdata : '0;
  assign o_resp_err       = w_in_resp & r_err;

endmodule

// File: tb/tb_river_mem_arbiter.sv
// Bench for river_mem_arbiter: directed vector table, reset/idle corner
// sequences, then randomized transactions against a grant model.
module tb_river_mem_arbiter;

  localparam int unsigned AB = 48;
  localparam int unsigned LB = 256;
  localparam int unsigned SB = LB / 8;

  logic              i_clk;
  logic              i_rst;
  logic [1:0]        i_req_valid;
  logic [1:0]        o_req_ready;
  logic [1:0]        i_req_write;
  logic [1:0]        i_req_cached;
  logic [2*AB-1:0]   i_req_addr;
  logic [5:0]        i_req_size;
  logic [2*LB-1:0]   i_req_wdata;
  logic [2*SB-1:0]   i_req_wstrb;
  logic [1:0]        o_resp_valid;
  logic [LB-1:0]     o_resp_data;
  logic              o_resp_err;
  logic [1:0]        i_resp_ready;
  logic              o_mem_req_valid;
  logic              i_mem_req_ready;
  logic              o_mem_req_path;
  logic              o_mem_req_write;
  logic              o_mem_req_cached;
  logic [AB-1:0]     o_mem_req_addr;
  logic [2:0]        o_mem_req_size;
  logic [LB-1:0]     o_mem_req_wdata;
  logic [SB-1:0]     o_mem_req_wstrb;
  logic              i_mem_resp_valid;
  logic [LB-1:0]     i_mem_resp_data;
  logic              i_mem_resp_err;
  logic              o_mem_resp_ready;

  river_mem_arbiter #(.abits(AB), .linebits(LB)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_cached(i_req_cached),
    .i_req_addr(i_req_addr), .i_req_size(i_req_size),
    .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data),
    .o_resp_err(o_resp_err), .i_resp_ready(i_resp_ready),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_path(o_mem_req_path), .o_mem_req_write(o_mem_req_write),
    .o_mem_req_cached(o_mem_req_cached), .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_size(o_mem_req_size), .o_mem_req_wdata(o_mem_req_wdata),
    .o_mem_req_wstrb(o_mem_req_wstrb), .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_data(i_mem_resp_data), .i_mem_resp_err(i_mem_resp_err),
    .o_mem_resp_ready(o_mem_resp_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [1:0]  cached;
    logic [1:0]  hold;
    logic [47:0] addr0;
    logic [47:0] addr1;
    logic [2:0]  size0;
    logic [2:0]  size1;
    int          req_wait;
    int          resp_delay;
    int          rr_wait;
    logic [7:0]  rbyte;
    logic        err;
    int          g_fixed;
    int          g_rr;
  } vec_t;

  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    write;
    logic [1:0]    cached;
    logic [1:0]    hold;
    logic [AB-1:0] addr0;
    logic [AB-1:0] addr1;
    logic [2:0]    size0;
    logic [2:0]    size1;
    logic [LB-1:0] wd0;
    logic [LB-1:0] wd1;
    logic [SB-1:0] ws0;
    logic [SB-1:0] ws1;
    int            req_wait;
    int            resp_delay;
    int            rr_wait;
    logic [LB-1:0] rdata;
    logic          err;
  } txn_t;

  int n_pass;
  int n_total;
  int m_last;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Grant the spec's arbitration rule would produce for a set of valid paths
  function automatic int model_grant(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef RIVER_MEM_ARB_RR_EN
    return 1 - m_last;
`else
    return 1;
`endif
  endfunction

  task automatic scramble_req();
    i_req_valid  = 2'($urandom);
    i_req_write  = 2'($urandom);
    i_req_cached = 2'($urandom);
    i_req_addr   = {$urandom, $urandom, $urandom};
    i_req_size   = 6'($urandom);
    for (int j = 0; j < 16; j++) i_req_wdata[j*32 +: 32] = $urandom;
    i_req_wstrb  = {$urandom, $urandom};
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"},      256'(o_req_ready), 256'(0));
    chk({tag, "_resp_valid"},     256'(o_resp_valid), 256'(0));
    chk({tag, "_resp_data"},      256'(o_resp_data), 256'(0));
    chk({tag, "_resp_err"},       256'(o_resp_err), 256'(0));
    chk({tag, "_mem_req_valid"},  256'(o_mem_req_valid), 256'(0));
    chk({tag, "_mem_req_fields"}, 256'({o_mem_req_path, o_mem_req_write, o_mem_req_cached,
                                        o_mem_req_addr, o_mem_req_size}), 256'(0));
    chk({tag, "_mem_req_wdata"},  256'(o_mem_req_wdata), 256'(0));
    chk({tag, "_mem_req_wstrb"},  256'(o_mem_req_wstrb), 256'(0));
    chk({tag, "_mem_resp_ready"}, 256'(o_mem_resp_ready), 256'(0));
  endtask

  // Full transaction; entered and left at posedge+1 with the DUT idle
  task automatic run_txn(input txn_t t, input int g, input string tag);
    logic [1:0]    oh;
    logic [AB-1:0] ea;
    logic [2:0]    es;
    logic [LB-1:0] ew;
    logic [SB-1:0] ewm;
    oh  = (g == 1) ? 2'b10 : 2'b01;
    ea  = (g == 1) ? t.addr1 : t.addr0;
    es  = (g == 1) ? t.size1 : t.size0;
    ew  = (g == 1) ? t.wd1 : t.wd0;
    ewm = (g == 1) ? t.ws1 : t.ws0;
    i_req_valid      = t.valid;
    i_req_write      = t.write;
    i_req_cached     = t.cached;
    i_req_addr       = {t.addr1, t.addr0};
    i_req_size       = {t.size1, t.size0};
    i_req_wdata      = {t.wd1, t.wd0};
    i_req_wstrb      = {t.ws1, t.ws0};
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_resp_ready     = 2'b00;
    #1;
    chk({tag, "_grant"}, 256'(o_req_ready), 256'(oh));
    chk({tag, "_idle_mem_valid"}, 256'(o_mem_req_valid), 256'(0));
    cyc();
    for (int k = 0; k <= t.req_wait; k++) begin
      scramble_req();
      i_mem_req_ready = (k == t.req_wait);
      #1;
      chk({tag, "_req_ready_busy"}, 256'(o_req_ready), 256'(0));
      chk({tag, "_mem_valid"}, 256'(o_mem_req_valid), 256'(1));
      chk({tag, "_mem_path"}, 256'(o_mem_req_path), 256'(g));
      chk({tag, "_mem_write"}, 256'(o_mem_req_write), 256'(t.write[g]));
      chk({tag, "_mem_cached"}, 256'(o_mem_req_cached), 256'(t.cached[g]));
      chk({tag, "_mem_addr"}, 256'(o_mem_req_addr), 256'(ea));
      chk({tag, "_mem_size"}, 256'(o_mem_req_size), 256'(es));
      chk({tag, "_mem_wdata"}, 256'(o_mem_req_wdata), 256'(ew));
      chk({tag, "_mem_wstrb"}, 256'(o_mem_req_wstrb), 256'(ewm));
      chk({tag, "_mem_resp_ready_req"}, 256'(o_mem_resp_ready), 256'(0));
      cyc();
    end
    i_mem_req_ready = 1'b0;
    for (int k = 0; k <= t.resp_delay; k++) begin
      scramble_req();
      i_mem_resp_valid = (k == t.resp_delay);
      i_mem_resp_data  = (k == t.resp_delay) ? t.rdata : {8{$urandom}};
      i_mem_resp_err   = (k == t.resp_delay) ? t.err : ~t.err;
      #1;
      chk({tag, "_wait_resp_ready"}, 256'(o_mem_resp_ready), 256'(1));
      chk({tag, "_wait_mem_valid"}, 256'(o_mem_req_valid), 256'(0));
      chk({tag, "_wait_resp_valid"}, 256'(o_resp_valid), 256'(0));
      chk({tag, "_wait_req_ready"}, 256'(o_req_ready), 256'(0));
      cyc();
    end
    for (int k = 0; k <= t.rr_wait; k++) begin
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = {8{$urandom}};
      i_mem_resp_err   = ~t.err;
      i_req_valid      = t.hold;
      i_resp_ready     = (k == t.rr_wait) ? oh : ~oh;
      #1;
      chk({tag, "_resp_valid"}, 256'(o_resp_valid), 256'(oh));
      chk({tag, "_resp_err"}, 256'(o_resp_err), 256'(t.err));
      if (!t.write[g]) chk({tag, "_resp_data"}, 256'(o_resp_data), 256'(t.rdata));
      chk({tag, "_resp_req_ready"}, 256'(o_req_ready), 256'(0));
      chk({tag, "_resp_mem_resp_ready"}, 256'(o_mem_resp_ready), 256'(0));
      cyc();
    end
    i_mem_resp_valid = 1'b0;
    i_resp_ready     = 2'b00;
  endtask

  function automatic txn_t from_vec(input vec_t v, input int i);
    txn_t t;
    t.valid = v.valid;   t.write = v.write;   t.cached = v.cached; t.hold = v.hold;
    t.addr0 = v.addr0;   t.addr1 = v.addr1;   t.size0 = v.size0;   t.size1 = v.size1;
    t.wd0   = {8{32'hC0DE0000 | 32'(i)}};
    t.wd1   = {8{32'hBEEF0000 | 32'(i)}};
    t.ws0   = {4{8'h0F ^ 8'(i)}};
    t.ws1   = '1;
    t.req_wait = v.req_wait; t.resp_delay = v.resp_delay; t.rr_wait = v.rr_wait;
    t.rdata = {32{v.rbyte}};
    t.err   = v.err;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   g;
    logic [63:0] r64a;
    logic [63:0] r64b;
    n_pass = 0;
    n_total = 0;
    m_last = 0;
    i_rst = 1'b1;
    i_req_valid = 2'b00; i_req_write = 2'b00; i_req_cached = 2'b00;
    i_req_addr = '0; i_req_size = '0; i_req_wdata = '0; i_req_wstrb = '0;
    i_resp_ready = 2'b00; i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0;
    i_mem_resp_data = '0; i_mem_resp_err = 1'b0;

    //          valid  write  cached hold   addr0            addr1            s0    s1    rw rd rr  byte   err gf gr
    vecs[0] = '{2'b01, 2'b00, 2'b01, 2'b00, 48'h0000_8000_1000, 48'h0000_9000_0000, 3'd5, 3'd3, 0, 1, 0, 8'hA5, 1'b0, 0, 0};
    vecs[1] = '{2'b11, 2'b00, 2'b11, 2'b00, 48'h0000_0000_1000, 48'h0000_0000_2000, 3'd5, 3'd5, 0, 0, 0, 8'h11, 1'b0, 1, 1};
    vecs[2] = '{2'b11, 2'b01, 2'b10, 2'b00, 48'h0000_0000_1040, 48'h0000_0000_2040, 3'd2, 3'd3, 1, 2, 1, 8'h22, 1'b0, 1, 0};
    vecs[3] = '{2'b11, 2'b10, 2'b00, 2'b00, 48'h0000_0000_1080, 48'h0000_0000_2080, 3'd5, 3'd4, 0, 0, 0, 8'h33, 1'b0, 1, 1};
    vecs[4] = '{2'b11, 2'b11, 2'b11, 2'b00, 48'h0000_0000_10C0, 48'h0000_0000_20C0, 3'd1, 3'd6, 2, 1, 0, 8'h44, 1'b1, 1, 0};
    vecs[5] = '{2'b10, 2'b10, 2'b10, 2'b00, 48'h0000_0000_1100, 48'h0000_8000_2000, 3'd0, 3'd5, 5, 1, 0, 8'h55, 1'b1, 1, 1};
    vecs[6] = '{2'b01, 2'b00, 2'b01, 2'b01, 48'h0000_8000_3000, 48'h0000_0000_0000, 3'd5, 3'd0, 0, 1, 3, 8'h66, 1'b0, 0, 0};
    vecs[7] = '{2'b01, 2'b01, 2'b00, 2'b00, 48'h0000_8000_3040, 48'h0000_0000_0000, 3'd2, 3'd0, 0, 0, 0, 8'h77, 1'b0, 0, 0};

    cyc();
    cyc();
    i_rst = 1'b0;
    #1;
    chk_zero("reset");
    cyc();

    for (int i = 0; i < 8; i++) begin
`ifdef RIVER_MEM_ARB_RR_EN
      g = vecs[i].g_rr;
`else
      g = vecs[i].g_fixed;
`endif
      run_txn(from_vec(vecs[i], i), g, $sformatf("vec%0d", i));
      m_last = g;
    end

    // Bridge response pulse while idle must be ignored
    i_req_valid = 2'b00;
    i_mem_resp_valid = 1'b1;
    i_mem_resp_data = {8{$urandom}};
    i_mem_resp_err = 1'b1;
    #1;
    chk("idle_pulse_resp_ready", 256'(o_mem_resp_ready), 256'(0));
    cyc();
    i_mem_resp_valid = 1'b0;
    #1;
    chk_zero("idle_pulse");
    cyc();

    // Reset while waiting for the bridge response
    t = from_vec(vecs[0], 9);
    i_req_valid = 2'b01;
    i_req_addr = {t.addr1, t.addr0};
    i_req_size = {t.size1, t.size0};
    i_req_write = 2'b00;
    cyc();
    i_req_valid = 2'b00;
    i_mem_req_ready = 1'b1;
    #1;
    chk("rst_seq_mem_valid", 256'(o_mem_req_valid), 256'(1));
    cyc();
    i_mem_req_ready = 1'b0;
    #1;
    chk("rst_seq_in_wait", 256'(o_mem_resp_ready), 256'(1));
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    #1;
    chk_zero("after_rst");
    cyc();
    m_last = 0;
    run_txn(t, 0, "post_rst");
    m_last = 0;

    // Randomized transactions against the grant model
    for (int i = 0; i < 30; i++) begin
      r64a = {$urandom, $urandom};
      r64b = {$urandom, $urandom};
      t.valid  = 2'($urandom_range(1, 3));
      t.write  = 2'($urandom);
      t.cached = 2'($urandom);
      t.hold   = 2'($urandom);
      t.addr0  = r64a[47:0];
      t.addr1  = r64b[47:0];
      t.size0  = 3'($urandom);
      t.size1  = 3'($urandom);
      t.wd0    = {8{$urandom}};
      t.wd1    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      t.ws0    = $urandom;
      t.ws1    = $urandom;
      t.req_wait   = $urandom_range(0, 3);
      t.resp_delay = $urandom_range(0, 3);
      t.rr_wait    = $urandom_range(0, 2);
      t.rdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      t.err    = 1'($urandom);
      g = model_grant(t.valid);
      run_txn(t, g, $sformatf("rnd%0d", i));
      m_last = g;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
